// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg: shared slot states and decoded instruction type codes
package dispatch_ctrl_pkg;
  typedef enum logic {EMPTY, HOLD} slot_state_t;
  localparam logic [2:0] TYPE_ALU = 3'd0;
  localparam logic [2:0] TYPE_BR  = 3'd1;
  localparam logic [2:0] TYPE_LS  = 3'd2;
  localparam logic [2:0] TYPE_JMP = 3'd3;
endpackage

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: one-entry holding slot feeding the dispatcher, issuing to ROB plus RS or LSB
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                if_valid,
  input  logic [31:0]         if_inst,
  input  logic [31:0]         if_pc,
  input  logic [31:0]         if_jpc,
  output logic                if_ready,
  output logic                disp_flag,
  output logic [31:0]         disp_inst,
  output logic [31:0]         disp_pc,
  output logic [31:0]         disp_jpc,
  input  logic [2:0]          dec_type,
  input  logic                rob_full,
  input  logic                rs_full,
  input  logic                lsb_full,
  output logic                rob_issue,
  output logic                rs_issue,
  output logic                lsb_issue,
  output logic [STALL_CW-1:0] stall_cnt
);
  slot_state_t state, state_nx;
  logic is_ls, tgt_full, fire, accept, live, stall;
  // issue decision, intake handshake and next slot state
  always_comb begin
    live      = rst_n & rdy & ~rollback;
    is_ls     = dec_type == TYPE_LS;
    tgt_full  = is_ls ? lsb_full : rs_full;
    fire      = live & (state == HOLD) & ~rob_full & ~tgt_full;
    if_ready  = live & ((state == EMPTY) | fire);
    accept    = if_valid & if_ready;
    stall     = live & (state == HOLD) & ~fire;
    rob_issue = fire;
    rs_issue  = fire & ~is_ls;
    lsb_issue = fire & is_ls;
    disp_flag = state == HOLD;
    state_nx  = ~rdy ? state : rollback ? EMPTY : accept ? HOLD : fire ? EMPTY : state;
  end
  // slot state, held instruction and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      disp_inst <= '0;
      disp_pc   <= '0;
      disp_jpc  <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        disp_inst <= if_inst;
        disp_pc   <= if_pc;
        disp_jpc  <= if_jpc;
      end
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
